// File: rtl/cd4510b.sv
// cd4510b: presettable 4-bit up/down counter modelled on the CD4510B (BCD, MODULUS=10)
// and CD4516B (binary, MODULUS=16). Asynchronous clear, level-transparent asynchronous
// preset, ripple-cascadable through the active-low carry pair.
module cd4510b #(
  parameter int MODULUS = 10  // 10 (BCD) or 16 (binary); other values are not meaningful
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       preset_en,
  input  logic       ncarry_in,
  input  logic       up_down,
  input  logic [3:0] jam,
  output logic [3:0] q,
  output logic       ncarry_out
);

  // Highest in-range state; also the up-count terminal value.
  localparam logic [3:0] LP_TOP = 4'(MODULUS - 1);

  logic       w_load;      // preset active and not overridden by reset
  logic [3:0] w_q_cur;     // held state when no load is in progress
  logic [3:0] w_q_next;    // state taken at the next counting edge
  logic       w_term;      // terminal count for the current direction
  logic [3:0] r_count;     // clocked counter state
  logic [3:0] r_jam;       // last jam value seen while the load was active
  logic       r_loaded;    // 1: the state lives in r_jam until the next clk edge

  // Reset dominates the preset, so a load is only live while reset is low.
  assign w_load = preset_en & ~reset;

  // Capture jam transparently during a load so q keeps the final jam value once
  // preset_en falls, even if jam moved without any clock edge.
  always_latch begin
    if (w_load) r_jam <= jam;
  end

  // After a load the held value comes from the jam capture until a clk edge
  // copies it (or its successor) into the counter register.
  assign w_q_cur = r_loaded ? r_jam : r_count;

  // Visible state: jam while loading, otherwise the held/counted value.
  assign q = w_load ? jam : w_q_cur;

  // Next-state selection: hold, up with wrap (out-of-range states also go to 0),
  // or down with wrap (out-of-range states simply decrement).
  always_comb begin
    w_q_next = w_q_cur;
    if (!ncarry_in) begin
      if (up_down) begin
        w_q_next = (w_q_cur >= LP_TOP) ? 4'd0 : w_q_cur + 4'd1;
      end else begin
        w_q_next = (w_q_cur == 4'd0) ? LP_TOP : w_q_cur - 4'd1;
      end
    end
  end

  // Carry-out is purely combinational on q, direction and carry-in; states above
  // the top value never match either terminal.
  always_comb begin
    w_term     = up_down ? (q == LP_TOP) : (q == 4'd0);
    ncarry_out = ~(~ncarry_in & w_term);
  end

  // Counter register: asynchronous clear; clock edges are ignored during a preset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (!preset_en) begin
      r_count <= w_q_next;
    end
  end

  // Load-source flag: set asynchronously when a load becomes live (including reset
  // falling while preset_en is already high), cleared by reset or the next clk edge.
  always_ff @(posedge clk or posedge reset or posedge w_load) begin
    if (reset) begin
      r_loaded <= 1'b0;
    end else if (w_load) begin
      r_loaded <= 1'b1;
    end else begin
      r_loaded <= 1'b0;
    end
  end

  // Undefined clock or asynchronous controls make the model meaningless.
  always_comb begin
    assert (!$isunknown({clk, reset, preset_en}));
  end

endmodule

// File: tb/tb_cd4510b.sv
// tb_cd4510b: directed stimulus for cd4510b with a queue-based scoreboard.
// Stimulus pushes hand-computed expectations; a monitor pops and compares them.
module tb_cd4510b;

  logic       clk = 1'b0;
  logic       reset, pa, pb, pc, ncin_a, ncin_c, up_down;
  logic [3:0] jam;
  logic [3:0] q_a, q_b, q_c;
  logic       nco_a, nco_b, nco_c;

  always #5 clk = ~clk;

  // A and B form a two-stage BCD cascade; C is a binary counter.
  cd4510b #(.MODULUS(10)) u_a (
    .clk(clk), .reset(reset), .preset_en(pa), .ncarry_in(ncin_a),
    .up_down(up_down), .jam(jam), .q(q_a), .ncarry_out(nco_a)
  );
  cd4510b #(.MODULUS(10)) u_b (
    .clk(clk), .reset(reset), .preset_en(pb), .ncarry_in(nco_a),
    .up_down(up_down), .jam(jam), .q(q_b), .ncarry_out(nco_b)
  );
  cd4510b #(.MODULUS(16)) u_c (
    .clk(clk), .reset(reset), .preset_en(pc), .ncarry_in(ncin_c),
    .up_down(up_down), .jam(jam), .q(q_c), .ncarry_out(nco_c)
  );

  localparam int DUT_A = 0;
  localparam int DUT_B = 1;
  localparam int DUT_C = 2;

  typedef struct {
    int         which;
    logic [3:0] q;
    logic       nco;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event strobe;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Hand-computed up-count sequence from 0 (BCD) and matching carry-out.
  logic [3:0] t1_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic       t1_c [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  // Down from 2: 1, 0, 9, 8.
  logic [3:0] t2_q [4]  = '{4'd1, 4'd0, 4'd9, 4'd8};
  logic       t2_c [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};

  // Monitor: whenever stimulus strobes, drain the queue and compare against the DUTs.
  initial begin
    forever begin
      @(strobe);
      while (exp_q.size() > 0) begin
        exp_t       e;
        logic [3:0] aq;
        logic       an;
        e = exp_q.pop_front();
        case (e.which)
          DUT_A:   begin aq = q_a; an = nco_a; end
          DUT_B:   begin aq = q_b; an = nco_b; end
          default: begin aq = q_c; an = nco_c; end
        endcase
        n_cmp++;
        if (aq !== e.q || an !== e.nco) begin
          n_bad++;
          $display("FAIL %s: got q=%0d ncarry_out=%0b, expected q=%0d ncarry_out=%0b",
                   e.name, aq, an, e.q, e.nco);
        end else begin
          $display("ok   %s: q=%0d ncarry_out=%0b", e.name, aq, an);
        end
      end
    end
  end

  task automatic chk(input int which, input logic [3:0] eq, input logic en, input string name);
    exp_t e;
    #1;
    e.which = which;
    e.q     = eq;
    e.nco   = en;
    e.name  = name;
    exp_q.push_back(e);
    -> strobe;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; pa = 1'b0; pb = 1'b0; pc = 1'b0;
    ncin_a = 1'b1; ncin_c = 1'b1; up_down = 1'b1; jam = 4'd0;
    #2;
    chk(DUT_A, 4'd0, 1'b1, "reset_a");
    chk(DUT_C, 4'd0, 1'b1, "reset_c");
    chk(DUT_B, 4'd0, 1'b1, "reset_b");

    // Up-count from reset through the BCD wrap.
    reset = 1'b0; ncin_a = 1'b0; up_down = 1'b1;
    chk(DUT_A, 4'd0, 1'b1, "t1_released");
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk(DUT_A, t1_q[k], t1_c[k], "t1_up");
    end

    // Preset 2, then count down through the wrap.
    pa = 1'b1; jam = 4'd2; up_down = 1'b0;
    chk(DUT_A, 4'd2, 1'b1, "t2_load");
    pa = 1'b0;
    chk(DUT_A, 4'd2, 1'b1, "t2_load_released");
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk(DUT_A, t2_q[k], t2_c[k], "t2_down");
    end

    // Level-transparent preset, clocks ignored while loading, value retained after.
    pa = 1'b1; jam = 4'd3;
    chk(DUT_A, 4'd3, 1'b1, "t3_jam3");
    jam = 4'd7;
    chk(DUT_A, 4'd7, 1'b1, "t3_jam7");
    step(1);
    chk(DUT_A, 4'd7, 1'b1, "t3_clk_ignored_1");
    step(1);
    chk(DUT_A, 4'd7, 1'b1, "t3_clk_ignored_2");
    jam = 4'd4;
    #1 pa = 1'b0;
    #1 jam = 4'd0;
    chk(DUT_A, 4'd4, 1'b1, "t3_retain_last_jam");
    step(1);
    chk(DUT_A, 4'd3, 1'b1, "t3_count_from_load");

    // Two-stage cascade, 25 clocks from 0.
    reset = 1'b1; up_down = 1'b1;
    chk(DUT_A, 4'd0, 1'b1, "t4_reset_a");
    chk(DUT_B, 4'd0, 1'b1, "t4_reset_b");
    reset = 1'b0; ncin_a = 1'b0;
    step(9);
    chk(DUT_A, 4'd9, 1'b0, "t4_a_at_9");
    chk(DUT_B, 4'd0, 1'b1, "t4_b_at_0");
    up_down = 1'b0;
    chk(DUT_A, 4'd9, 1'b1, "t4_dir_change_carry");
    up_down = 1'b1;
    step(16);
    chk(DUT_A, 4'd5, 1'b1, "t4_a_after_25");
    chk(DUT_B, 4'd2, 1'b1, "t4_b_after_25");
    ncin_a = 1'b1;
    step(5);
    chk(DUT_A, 4'd5, 1'b1, "t4_a_inhibited");
    chk(DUT_B, 4'd2, 1'b1, "t4_b_inhibited");
    ncin_a = 1'b0;
    step(4);
    chk(DUT_A, 4'd9, 1'b0, "t4_a_terminal");
    ncin_a = 1'b1;
    chk(DUT_A, 4'd9, 1'b1, "t4_inhibit_kills_carry");
    step(3);
    chk(DUT_A, 4'd9, 1'b1, "t4_a_hold_at_9");
    chk(DUT_B, 4'd2, 1'b1, "t4_b_hold");

    // Reset between edges, overriding an active preset.
    step(1);
    pa = 1'b1; jam = 4'd6;
    chk(DUT_A, 4'd6, 1'b1, "t5_load6");
    pa = 1'b0; ncin_a = 1'b0;
    chk(DUT_A, 4'd6, 1'b1, "t5_at_6");
    reset = 1'b1; pa = 1'b1;
    chk(DUT_A, 4'd0, 1'b1, "t5_reset_async");
    step(1);
    chk(DUT_A, 4'd0, 1'b1, "t5_reset_holds_over_clk");
    pa = 1'b0;
    #1 reset = 1'b0;
    chk(DUT_A, 4'd0, 1'b1, "t5_released");
    step(1);
    chk(DUT_A, 4'd1, 1'b1, "t5_first_count");

    // Binary counter wrap and carry.
    ncin_a = 1'b1;
    pc = 1'b1; jam = 4'd14; up_down = 1'b1;
    chk(DUT_C, 4'd14, 1'b1, "t6_c_load14");
    pc = 1'b0; ncin_c = 1'b0;
    chk(DUT_C, 4'd14, 1'b1, "t6_c_at_14");
    step(1);
    chk(DUT_C, 4'd15, 1'b0, "t6_c_at_15");
    step(1);
    chk(DUT_C, 4'd0, 1'b1, "t6_c_wrap_0");
    up_down = 1'b0;
    chk(DUT_C, 4'd0, 1'b0, "t6_c_down_terminal");
    step(1);
    chk(DUT_C, 4'd15, 1'b1, "t6_c_down_wrap_15");

    // BCD out-of-range states reached through jam.
    ncin_c = 1'b1;
    pa = 1'b1; jam = 4'd12; up_down = 1'b1;
    chk(DUT_A, 4'd12, 1'b1, "t6_a_load12_up");
    pa = 1'b0; ncin_a = 1'b0;
    chk(DUT_A, 4'd12, 1'b1, "t6_a_12_no_carry");
    step(1);
    chk(DUT_A, 4'd0, 1'b1, "t6_a_12_up_to_0");
    pa = 1'b1; jam = 4'd12; up_down = 1'b0;
    chk(DUT_A, 4'd12, 1'b1, "t6_a_load12_down");
    pa = 1'b0;
    chk(DUT_A, 4'd12, 1'b1, "t6_a_12_down_no_carry");
    step(1);
    chk(DUT_A, 4'd11, 1'b1, "t6_a_12_down_to_11");
    step(1);
    chk(DUT_A, 4'd10, 1'b1, "t6_a_down_to_10");
    step(1);
    chk(DUT_A, 4'd9, 1'b1, "t6_a_down_to_9");
    ncin_a = 1'b1;

    #5;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
